// File: rtl/nv_backup_ctrl_if.sv
// nv_backup_ctrl_if
//   Groups the signals between the core and the backup controller:
//   dirty flags, the backup strobes and acks, and the restore strobes.
//
//   Parameters:
//     NREG - number of backed-up core registers
//     W    - register width in bits
//
//   Signals:
//     dirty_vals   [2*NREG]  core -> ctrl  per-register dirty flags, 2'b00 = clean
//     backup_ens   [NREG]    ctrl -> core  one-hot, core presents register i
//     backup_Vouts [NREG*W]  core -> ctrl  flat register values, slice i = [i*W +: W]
//     backup_acks  [NREG]    ctrl -> core  one-cycle pulse, core clears dirty flag i
//     restore_ens  [NREG]    ctrl -> core  one-hot write strobe
//     restore_Vins [NREG*W]  ctrl -> core  restore data, slice i valid with restore_ens[i]
//
//   Modports:
//     master - the backup controller
//     slave  - the core
interface nv_backup_ctrl_if #(
  parameter int NREG = 53,
  parameter int W    = 32
);
  logic [2*NREG-1:0] dirty_vals;
  logic [NREG-1:0]   backup_ens;
  logic [NREG*W-1:0] backup_Vouts;
  logic [NREG-1:0]   backup_acks;
  logic [NREG-1:0]   restore_ens;
  logic [NREG*W-1:0] restore_Vins;

  modport master (
    input  dirty_vals, backup_Vouts,
    output backup_ens, backup_acks, restore_ens, restore_Vins
  );

  modport slave (
    output dirty_vals, backup_Vouts,
    input  backup_ens, backup_acks, restore_ens, restore_Vins
  );
endinterface

// File: rtl/nv_backup_ctrl.sv
// nv_backup_ctrl
//   Responder side of the core's register backup/restore interface.
//   On Pwr_off it walks the dirty flags and copies each dirty register into
//   an internal non-volatile store, then raises Pwr_ack. On Wake it replays
//   every valid stored word back into the core and pulses Restore_done.
//
//   Optional feature (macro NV_PARITY_EN):
//     Each stored word also keeps an even parity bit. A valid entry whose
//     parity no longer matches is skipped on restore and sets the sticky
//     Restore_err flag. Without the macro Restore_err is tied to 0.
//
//   Ports:
//     Clk          in   system clock, rising edge
//     Rst          in   asynchronous active-low reset
//     Pwr_off      in   level, request backup and power-down
//     Wake         in   level, request restore after power-down
//     Nv_clr       in   clears all store valid bits, honoured in IDLE only
//     bus          if   core-side dirty/backup/restore signals (master modport)
//     Pwr_ack      out  backup complete, held high while powered down
//     Busy         out  high in any state except IDLE and OFF
//     Restore_done out  one-cycle pulse at end of restore
//     Restore_err  out  sticky parity error flag
module nv_backup_ctrl #(
  parameter int NREG  = 53,
  parameter int W     = 32,
  parameter int IDX_W = 6
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Pwr_off,
  input  logic             Wake,
  input  logic             Nv_clr,
  nv_backup_ctrl_if.master bus,
  output logic             Pwr_ack,
  output logic             Busy,
  output logic             Restore_done,
  output logic             Restore_err
);

  typedef enum logic [2:0] {
    IDLE, BK_SCAN, BK_CAPT, BK_ACK, OFF, RS_SCAN, RS_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             last_idx;
  logic             rs_hit;
  logic [NREG-1:0]  one_hot;
  logic [NREG-1:0]  rs_ens;

  // Non-volatile store: deliberately outside the reset domain.
  logic [W-1:0]     store [NREG];
  logic [NREG-1:0]  valid;

  // Unpacked views of the flat core buses so they can be indexed by idx.
  logic [W-1:0]     vout_arr  [NREG];
  logic [1:0]       dirty_arr [NREG];

  for (genvar g = 0; g < NREG; g++) begin : g_slices
    assign vout_arr[g]                   = bus.backup_Vouts[g*W +: W];
    assign dirty_arr[g]                  = bus.dirty_vals[2*g +: 2];
    assign bus.restore_Vins[g*W +: W]    = rs_ens[g] ? store[g] : '0;
  end

  assign last_idx = (idx == IDX_W'(NREG - 1));
  assign one_hot  = {{(NREG-1){1'b0}}, 1'b1} << idx;

`ifdef NV_PARITY_EN
  logic [NREG-1:0] par;
  logic            par_ok;

  assign par_ok = ((^store[idx]) == par[idx]);
`else
  logic            par_ok;

  assign par_ok = 1'b1;
`endif

  // An entry is replayed only if it is valid and (when enabled) its parity holds.
  assign rs_hit = (state == RS_SCAN) && valid[idx] && par_ok;

  // State and index register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic and strobes; all strobes derive from the current state so
  // an asynchronous reset clears them immediately.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    bus.backup_ens  = '0;
    bus.backup_acks = '0;
    rs_ens          = '0;
    Pwr_ack         = 1'b0;
    Busy            = 1'b1;
    Restore_done    = 1'b0;

    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Pwr_off) begin
          state_nxt = BK_SCAN;
          idx_nxt   = '0;
        end
      end
      BK_SCAN: begin
        if (dirty_arr[idx] != 2'b00) begin
          state_nxt = BK_CAPT;
        end else if (last_idx) begin
          state_nxt = OFF;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      BK_CAPT: begin
        bus.backup_ens = one_hot;
        state_nxt      = BK_ACK;
      end
      BK_ACK: begin
        bus.backup_acks = one_hot;
        if (last_idx) begin
          state_nxt = OFF;
        end else begin
          state_nxt = BK_SCAN;
          idx_nxt   = idx + 1'b1;
        end
      end
      OFF: begin
        Busy    = 1'b0;
        Pwr_ack = 1'b1;
        if (Wake) begin
          state_nxt = RS_SCAN;
          idx_nxt   = '0;
        end
      end
      RS_SCAN: begin
        if (rs_hit) begin
          rs_ens = one_hot;
        end
        if (last_idx) begin
          state_nxt = RS_DONE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      RS_DONE: begin
        Restore_done = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.restore_ens = rs_ens;

  // Store capture and valid bookkeeping. Pwr_off takes priority over Nv_clr.
  always_ff @(posedge Clk) begin
    if (state == BK_ACK) begin
      store[idx] <= vout_arr[idx];
      valid[idx] <= 1'b1;
`ifdef NV_PARITY_EN
      par[idx]   <= ^vout_arr[idx];
`endif
    end else if ((state == IDLE) && !Pwr_off && Nv_clr) begin
      valid <= '0;
    end
  end

`ifdef NV_PARITY_EN
  // Sticky error; cleared when a new backup begins.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Restore_err <= 1'b0;
    end else if ((state == IDLE) && Pwr_off) begin
      Restore_err <= 1'b0;
    end else if ((state == RS_SCAN) && valid[idx] && !par_ok) begin
      Restore_err <= 1'b1;
    end
  end
`else
  assign Restore_err = 1'b0;
`endif

endmodule

// File: tb/tb_nv_backup_ctrl.sv
// tb_nv_backup_ctrl
//   Self-checking bench for nv_backup_ctrl. Expected backup/restore strobes
//   are queued as stimulus is set up and popped by a negedge monitor as the
//   DUT produces them. Define NV_PARITY_EN to exercise the parity feature.
module tb_nv_backup_ctrl;
  localparam int NREG  = 53;
  localparam int W     = 32;
  localparam int IDX_W = 6;

  logic Clk     = 1'b0;
  logic Rst     = 1'b0;
  logic Pwr_off = 1'b0;
  logic Wake    = 1'b0;
  logic Nv_clr  = 1'b0;
  logic Pwr_ack, Busy, Restore_done, Restore_err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int           idx;
    logic [W-1:0] val;
  } rs_item_t;

  rs_item_t rs_q[$];
  int       bk_ens_q[$];
  int       bk_ack_q[$];

  nv_backup_ctrl_if #(.NREG(NREG), .W(W)) bus ();

  nv_backup_ctrl #(.NREG(NREG), .W(W), .IDX_W(IDX_W)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Pwr_off      (Pwr_off),
    .Wake         (Wake),
    .Nv_clr       (Nv_clr),
    .bus          (bus),
    .Pwr_ack      (Pwr_ack),
    .Busy         (Busy),
    .Restore_done (Restore_done),
    .Restore_err  (Restore_err)
  );

  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int first_bit(input logic [NREG-1:0] v);
    for (int i = 0; i < NREG; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Monitor: every strobe the DUT raises is matched against the scoreboard.
  int           mon_nb;
  int           mon_i;
  int           mon_exp;
  rs_item_t     mon_item;
  logic [NREG*W-1:0] mon_vins;

  always @(negedge Clk) begin
    mon_nb = $countones(bus.backup_ens) + $countones(bus.backup_acks)
           + $countones(bus.restore_ens);
    if (mon_nb != 0) checkOutput("strobe_onehot", mon_nb, 1);
    if (bus.backup_ens != '0) begin
      mon_i   = first_bit(bus.backup_ens);
      mon_exp = (bk_ens_q.size() > 0) ? bk_ens_q.pop_front() : -1;
      checkOutput("bk_ens_idx", mon_i, mon_exp);
    end
    if (bus.backup_acks != '0) begin
      mon_i   = first_bit(bus.backup_acks);
      mon_exp = (bk_ack_q.size() > 0) ? bk_ack_q.pop_front() : -1;
      checkOutput("bk_ack_idx", mon_i, mon_exp);
    end
    if (bus.restore_ens != '0) begin
      mon_i = first_bit(bus.restore_ens);
      if (rs_q.size() > 0) mon_item = rs_q.pop_front();
      else mon_item = '{idx: -1, val: '0};
      checkOutput("rs_idx", mon_i, mon_item.idx);
      checkOutput("rs_val", bus.restore_Vins[mon_i*W +: W], mon_item.val);
      mon_vins = bus.restore_Vins;
      mon_vins[mon_i*W +: W] = '0;
      checkOutput("rs_other_slices_zero", (mon_vins == '0), 1'b1);
    end
  end

  task automatic applyStimulus(input logic p, input logic w, input logic c);
    @(negedge Clk);
    Pwr_off = p;
    Wake    = w;
    Nv_clr  = c;
  endtask

  task automatic setCore(input int i, input logic [1:0] d, input logic [W-1:0] v);
    bus.dirty_vals[2*i +: 2]  = d;
    bus.backup_Vouts[i*W +: W] = v;
  endtask

  // Raise Pwr_off (optionally with Nv_clr), drop it after 'hold' cycles and
  // count cycles from BK_SCAN entry until Pwr_ack.
  task automatic doBackup(input string tag, input int exp_cycles, input int hold,
                          input logic clr);
    int n = 0;
    applyStimulus(1'b1, 1'b0, clr);
    do begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (n >= hold) Pwr_off = 1'b0;
      Nv_clr = 1'b0;
    end while (!Pwr_ack && n < 400);
    checkOutput({tag, "_cycles"}, n - 1, exp_cycles);
    checkOutput({tag, "_ens_q_empty"}, bk_ens_q.size(), 0);
    checkOutput({tag, "_ack_q_empty"}, bk_ack_q.size(), 0);
  endtask

  // Raise Wake from OFF and wait for Restore_done.
  task automatic doRestore(input string tag);
    int n = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(posedge Clk);
    n++;
    @(negedge Clk);
    Wake = 1'b0;
    checkOutput({tag, "_pwr_ack_low"}, Pwr_ack, 1'b0);
    checkOutput({tag, "_busy"}, Busy, 1'b1);
    while (!Restore_done && n < 400) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
    end
    checkOutput({tag, "_cycles"}, n, 54);
    @(negedge Clk);
    checkOutput({tag, "_done_pulse"}, Restore_done, 1'b0);
    checkOutput({tag, "_idle"}, Busy, 1'b0);
    checkOutput({tag, "_q_empty"}, rs_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic reached;

    bus.dirty_vals = '0;
    for (int i = 0; i < NREG; i++) bus.backup_Vouts[i*W +: W] = $urandom;

    // Reset state.
    repeat (3) @(negedge Clk);
    checkOutput("rst_pwr_ack", Pwr_ack, 1'b0);
    checkOutput("rst_busy", Busy, 1'b0);
    checkOutput("rst_done", Restore_done, 1'b0);
    checkOutput("rst_err", Restore_err, 1'b0);
    checkOutput("rst_strobes", {bus.backup_ens, bus.backup_acks, bus.restore_ens}, '0);
    Rst = 1'b1;

    // Phase 1: clear store, clean backup, empty restore.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    doBackup("p1_backup", 53, 1, 1'b0);
    checkOutput("p1_pwr_ack_held", Pwr_ack, 1'b1);
    doRestore("p1_restore");

    // Phase 2: three dirty registers including both ends.
    setCore(0, 2'b01, 32'hDEADBEEF);
    setCore(7, 2'b10, 32'h00000001);
    setCore(52, 2'b11, 32'hFFFFFFFF);
    bk_ens_q = '{0, 7, 52};
    bk_ack_q = '{0, 7, 52};
    doBackup("p2_backup", 59, 1, 1'b0);
    bus.dirty_vals = '0;

    // Phase 3: replay of the three stored words.
    rs_q.push_back('{idx: 0,  val: 32'hDEADBEEF});
    rs_q.push_back('{idx: 7,  val: 32'h00000001});
    rs_q.push_back('{idx: 52, val: 32'hFFFFFFFF});
    doRestore("p3_restore");

    // Phase 4: reset while idx 7 is in BK_ACK.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    setCore(0, 2'b01, 32'h12345678);
    setCore(7, 2'b01, 32'hCAFEF00D);
    bk_ens_q = '{0, 7};
    bk_ack_q = '{0, 7};
    applyStimulus(1'b1, 1'b0, 1'b0);
    reached = 1'b0;
    n = 0;
    while (!reached && n < 200) begin
      @(negedge Clk);
      n++;
      Pwr_off = 1'b0;
      if (bus.backup_acks[7]) reached = 1'b1;
    end
    checkOutput("p4_reached_ack7", reached, 1'b1);
    #2 Rst = 1'b0;
    #1;
    checkOutput("p4_rst_strobes", {bus.backup_ens, bus.backup_acks, bus.restore_ens}, '0);
    checkOutput("p4_rst_busy", Busy, 1'b0);
    checkOutput("p4_rst_pwr_ack", Pwr_ack, 1'b0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    bus.dirty_vals = '0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge Clk);
    checkOutput("p4_wake_idle_busy", Busy, 1'b0);
    checkOutput("p4_wake_idle_pwr_ack", Pwr_ack, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    doBackup("p4_backup", 53, 1, 1'b0);
    rs_q.push_back('{idx: 0, val: 32'h12345678});
    doRestore("p4_restore");

    // Phase 5: Pwr_off with Nv_clr, Pwr_off dropped mid-scan.
    doBackup("p5_backup", 53, 10, 1'b1);
    rs_q.push_back('{idx: 0, val: 32'h12345678});
    doRestore("p5_restore");

`ifdef NV_PARITY_EN
    // Phase 6: corrupted entry is skipped and flagged.
    setCore(0, 2'b01, 32'hDEADBEEF);
    setCore(7, 2'b10, 32'h00000001);
    setCore(52, 2'b11, 32'hFFFFFFFF);
    bk_ens_q = '{0, 7, 52};
    bk_ack_q = '{0, 7, 52};
    doBackup("p6_backup", 59, 1, 1'b0);
    bus.dirty_vals = '0;
    dut.store[7] = 32'h00000009;
    rs_q.push_back('{idx: 0,  val: 32'hDEADBEEF});
    rs_q.push_back('{idx: 52, val: 32'hFFFFFFFF});
    doRestore("p6_restore");
    checkOutput("p6_restore_err_set", Restore_err, 1'b1);
    repeat (2) @(negedge Clk);
    checkOutput("p6_restore_err_sticky", Restore_err, 1'b1);
    doBackup("p6_rebackup", 53, 1, 1'b0);
    checkOutput("p6_restore_err_cleared", Restore_err, 1'b0);
`else
    checkOutput("restore_err_tied", Restore_err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
